baby_mem_wb: RTL and testbench

//  Parametrised shared program/data store for the Manchester Baby core. Replaces the fixed 32x32 RAM.
//  Two access paths: a CPU port for the Baby, and a Wishbone slave for the management SoC.
//  The SoC uses the Wishbone slave to load and inspect programs, start/halt the core and read its stop lamp.

---
 rtl/baby_mem_wb.sv | 212 +++++++++++++++++++++
 tb/tb_baby_mem_wb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_mem_wb.sv
// Shared program/data store for the Manchester Baby: CPU port plus Wishbone slave with CTRL/STAT registers.
// Optional per-word even parity is enabled by defining BABY_MEM_PARITY_EN.
module baby_mem_wb #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              reset_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_gnt_o,
  output logic              cpu_run_o,
  output logic              cpu_rst_no,
  input  logic              stop_lamp_i,
  output logic              irq_o
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned LANES    = DATA_W / 8;
  localparam logic [31:0] CTRL_OFF = 32'(4 * DEPTH);
  localparam logic [31:0] STAT_OFF = 32'(4 * DEPTH + 4);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_ACK
  } wbState_t;

  wbState_t r_state;
  wbState_t w_stateNext;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_cpuData;
  logic [31:0]       r_wbDat;
  logic              r_run;
  logic              r_crst;
  logic              r_stopped;
  logic              r_lampPrev;

  logic [31:0]       w_offset;
  logic              w_isMem;
  logic              w_isCtrl;
  logic              w_isStat;
  logic [ADDR_W-1:0] w_wbIdx;
  logic              w_wbReq;
  logic              w_wbExec;
  logic              w_wbMemGo;
  logic              w_cpuGnt;
  logic [ADDR_W-1:0] w_memAddr;
  logic              w_memWe;
  logic [DATA_W-1:0] w_memOld;
  logic [DATA_W-1:0] w_memNew;
  logic [31:0]       w_wbRdata;
  logic              w_ctrlWr;
  logic              w_statWr;
  logic              w_lampRise;
  logic              w_inj;
  logic              w_perr;

  assign w_offset = wbs_adr_i - WB_BASE;
  assign w_isMem  = (w_offset < CTRL_OFF) && (w_offset[1:0] == 2'b00);
  assign w_isCtrl = (w_offset == CTRL_OFF);
  assign w_isStat = (w_offset == STAT_OFF);
  assign w_wbIdx  = w_offset[ADDR_W+1:2];
  assign w_wbReq  = wbs_cyc_i & wbs_stb_i & reset_ni;

  // A WB memory access that lost to the CPU once wins unconditionally next cycle.
  always_comb begin
    w_stateNext = r_state;
    w_wbExec    = 1'b0;
    w_wbMemGo   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (w_wbReq) begin
          if (!w_isMem) begin
            w_wbExec    = 1'b1;
            w_stateNext = WB_ACK;
          end else if (!cpu_req_i) begin
            w_wbExec    = 1'b1;
            w_wbMemGo   = 1'b1;
            w_stateNext = WB_ACK;
          end else begin
            w_stateNext = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (w_wbReq) begin
          w_wbExec    = 1'b1;
          w_wbMemGo   = w_isMem;
          w_stateNext = WB_ACK;
        end else begin
          w_stateNext = WB_IDLE;
        end
      end
      WB_ACK:  w_stateNext = WB_IDLE;
      default: w_stateNext = WB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_ni) r_state <= WB_IDLE;
    else           r_state <= w_stateNext;
  end

  assign w_cpuGnt  = cpu_req_i & ~w_wbMemGo & reset_ni;
  assign w_memAddr = w_wbMemGo ? w_wbIdx : cpu_addr_i;
  assign w_memWe   = w_wbMemGo ? wbs_we_i : (w_cpuGnt & cpu_we_i);
  assign w_memOld  = r_mem[w_memAddr];

  // WB writes merge enabled byte lanes into the current word so parity covers the whole result.
  always_comb begin
    w_memNew = cpu_data_i;
    if (w_wbMemGo) begin
      w_memNew = w_memOld;
      for (int b = 0; b < LANES; b++) begin
        if (wbs_sel_i[b]) w_memNew[8*b +: 8] = wbs_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memNew;
  end

  always_comb begin
    w_wbRdata = '0;
    if (w_isMem)       w_wbRdata[DATA_W-1:0] = w_memOld;
    else if (w_isCtrl) w_wbRdata[2:0]        = {w_inj, r_crst, r_run};
    else if (w_isStat) w_wbRdata[2:0]        = {w_perr, r_stopped, stop_lamp_i};
  end

  assign w_ctrlWr   = w_wbExec & wbs_we_i & w_isCtrl & wbs_sel_i[0];
  assign w_statWr   = w_wbExec & wbs_we_i & w_isStat & wbs_sel_i[0];
  assign w_lampRise = stop_lamp_i & ~r_lampPrev & r_run;

  always_ff @(posedge wb_clk_i) begin
    if (!reset_ni) begin
      r_wbDat    <= '0;
      r_cpuData  <= '0;
      r_run      <= 1'b0;
      r_crst     <= 1'b1;
      r_stopped  <= 1'b0;
      r_lampPrev <= 1'b0;
    end else begin
      r_lampPrev <= stop_lamp_i;
      if (w_wbExec) r_wbDat <= wbs_we_i ? 32'd0 : w_wbRdata;
      if (w_cpuGnt && !cpu_we_i) r_cpuData <= w_memOld;
      if (w_ctrlWr) begin
        r_run  <= wbs_dat_i[0];
        r_crst <= wbs_dat_i[1];
      end
      if (w_lampRise) r_run <= 1'b0;
      if (w_statWr && wbs_dat_i[1]) r_stopped <= 1'b0;
      if (w_lampRise) r_stopped <= 1'b1;
    end
  end

`ifdef BABY_MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_inj;
  logic r_perr;
  logic w_memRe;
  logic w_parErr;

  assign w_memRe  = w_wbMemGo ? ~wbs_we_i : (w_cpuGnt & ~cpu_we_i);
  assign w_parErr = w_memRe & ((^w_memOld) != r_par[w_memAddr]);

  always_ff @(posedge wb_clk_i) begin
    if (w_memWe) r_par[w_memAddr] <= (^w_memNew) ^ r_inj;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_ni) begin
      r_inj  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_ctrlWr)     r_inj <= wbs_dat_i[2];
      else if (w_memWe) r_inj <= 1'b0;
      if (w_statWr && wbs_dat_i[2]) r_perr <= 1'b0;
      if (w_parErr) r_perr <= 1'b1;
    end
  end

  assign w_inj  = r_inj;
  assign w_perr = r_perr;
`else
  assign w_inj  = 1'b0;
  assign w_perr = 1'b0;
`endif

  assign wbs_ack_o  = (r_state == WB_ACK);
  assign wbs_dat_o  = r_wbDat;
  assign cpu_data_o = r_cpuData;
  assign cpu_gnt_o  = w_cpuGnt;
  assign cpu_run_o  = r_run;
  assign cpu_rst_no = ~r_crst;
  assign irq_o      = r_stopped | w_perr;

endmodule

// File: tb/tb_baby_mem_wb.sv
// Directed self-checking bench for baby_mem_wb: reset, WB load, byte lanes, contention, abort, run/stop, parity.
module tb_baby_mem_wb;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] CTRL_A = BASE + 32'h80;
  localparam logic [31:0] STAT_A = BASE + 32'h84;
`ifdef BABY_MEM_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetN;
  logic              wbStb, wbCyc, wbWe;
  logic [3:0]        wbSel;
  logic [31:0]       wbAdr, wbDatI;
  logic              wbAck;
  logic [31:0]       wbDatO;
  logic              cpuReq, cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuDatI;
  logic [DATA_W-1:0] cpuDataO;
  logic              cpuGnt, cpuRun, cpuRstN;
  logic              stopLamp;
  logic              irq;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  baby_mem_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BASE(BASE)) dut (
    .wb_clk_i   (clk),
    .reset_ni   (resetN),
    .wbs_stb_i  (wbStb),
    .wbs_cyc_i  (wbCyc),
    .wbs_we_i   (wbWe),
    .wbs_sel_i  (wbSel),
    .wbs_adr_i  (wbAdr),
    .wbs_dat_i  (wbDatI),
    .wbs_ack_o  (wbAck),
    .wbs_dat_o  (wbDatO),
    .cpu_req_i  (cpuReq),
    .cpu_we_i   (cpuWe),
    .cpu_addr_i (cpuAddr),
    .cpu_data_i (cpuDatI),
    .cpu_data_o (cpuDataO),
    .cpu_gnt_o  (cpuGnt),
    .cpu_run_o  (cpuRun),
    .cpu_rst_no (cpuRstN),
    .stop_lamp_i(stopLamp),
    .irq_o      (irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One Wishbone transaction; lat counts cycles from accept to ack (8 means no ack arrived).
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = we; wbAdr = adr; wbDatI = dat; wbSel = sel;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!wbAck && lat < 8);
    rdat = wbDatO;
    wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
  endtask

  task automatic cpuAccess(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           output logic gnt);
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuDatI = data;
    #1 gnt = cpuGnt;
    @(posedge clk);
    @(negedge clk);
    cpuReq = 1'b0; cpuWe = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        gnt;
    int          lat, ackLat, ackCount, gntLow;

    resetN = 1'b0; wbStb = 1'b0; wbCyc = 1'b0; wbWe = 1'b0; wbSel = 4'h0;
    wbAdr = '0; wbDatI = '0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuDatI = '0;
    stopLamp = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Make outputs non-zero, then reset again and confirm memory survives.
    applyStimulus(1'b1, BASE + 32'd12, 32'hA5A5_A5A5, 4'hF, rd, lat);
    applyStimulus(1'b1, CTRL_A, 32'h1, 4'hF, rd, lat);
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'hF, rd, lat);
    checkOutput("pre_rst_wb_mem3", rd, 32'hA5A5_A5A5);
    cpuAccess(1'b0, 5'd3, '0, gnt);
    checkOutput("pre_rst_cpu_mem3", cpuDataO, 32'hA5A5_A5A5);
    checkOutput("pre_rst_run", cpuRun, 1);

    @(negedge clk);
    resetN = 1'b0; cpuReq = 1'b1; cpuAddr = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ack", wbAck, 0);
    checkOutput("rst_wbdat", wbDatO, 0);
    checkOutput("rst_cpudat", cpuDataO, 0);
    checkOutput("rst_gnt", cpuGnt, 0);
    checkOutput("rst_run", cpuRun, 0);
    checkOutput("rst_crstn", cpuRstN, 0);
    checkOutput("rst_irq", irq, 0);
    resetN = 1'b1; cpuReq = 1'b0;
    applyStimulus(1'b0, CTRL_A, 32'h0, 4'hF, rd, lat);
    checkOutput("rst_ctrl", rd, 32'h2);
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'hF, rd, lat);
    checkOutput("rst_mem3_kept", rd, 32'hA5A5_A5A5);

    // WB load and read-back of the whole array.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, BASE + 32'(4 * i), 32'(i) * 32'h0101_0101, 4'hF, rd, lat);
      checkOutput($sformatf("load_wr_lat%0d", i), lat, 1);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, rd, lat);
      checkOutput($sformatf("load_rd%0d", i), rd, 32'(i) * 32'h0101_0101);
      checkOutput($sformatf("load_rd_lat%0d", i), lat, 1);
    end

    // Byte lanes.
    applyStimulus(1'b1, BASE + 32'd20, 32'hFFFF_FFFF, 4'hF, rd, lat);
    applyStimulus(1'b1, BASE + 32'd20, 32'h1234_5678, 4'b0101, rd, lat);
    applyStimulus(1'b0, BASE + 32'd20, 32'h0, 4'hF, rd, lat);
    checkOutput("lanes_mem5", rd, 32'hFF34_FF78);

    // CPU write then reads from both ports.
    cpuAccess(1'b1, 5'd10, 32'hDEAD_BEEF, gnt);
    checkOutput("cpu_wr_gnt", gnt, 1);
    applyStimulus(1'b0, BASE + 32'd40, 32'h0, 4'hF, rd, lat);
    checkOutput("cpu_wr_wb_rd", rd, 32'hDEAD_BEEF);
    cpuAccess(1'b0, 5'd10, '0, gnt);
    checkOutput("cpu_rd_mem10", cpuDataO, 32'hDEAD_BEEF);

    // Unmapped addresses read 0 and are still acked.
    applyStimulus(1'b1, BASE + 32'h100, 32'h5555_5555, 4'hF, rd, lat);
    checkOutput("unmapped_wr_lat", lat, 1);
    applyStimulus(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, lat);
    checkOutput("unmapped_rd", rd, 32'h0);
    applyStimulus(1'b0, BASE - 32'd4, 32'h0, 4'hF, rd, lat);
    checkOutput("below_base_rd", rd, 32'h0);
    checkOutput("below_base_lat", lat, 1);

    // Contention: CPU requests every cycle while WB reads MEM[7].
    @(negedge clk);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbAdr = BASE + 32'd28; wbSel = 4'hF;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 5'd2;
    ackLat = -1; ackCount = 0; gntLow = 0; rd = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (!cpuGnt) gntLow++;
      if (wbAck) begin
        ackCount++;
        if (ackLat < 0) begin
          ackLat = c;
          rd = wbDatO;
        end
        wbCyc = 1'b0; wbStb = 1'b0;
      end
      @(negedge clk);
    end
    cpuReq = 1'b0;
    checkOutput("cont_ack_lat", ackLat, 2);
    checkOutput("cont_ack_count", ackCount, 1);
    checkOutput("cont_gnt_low", gntLow, 1);
    checkOutput("cont_wb_data", rd, 32'h0707_0707);
    checkOutput("cont_cpu_data", cpuDataO, 32'h0202_0202);

    // Abort: WB write loses to CPU, then cyc drops before ack.
    @(negedge clk);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbAdr = BASE + 32'd48; wbDatI = 32'hFFFF_FFFF; wbSel = 4'hF;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 5'd0;
    @(negedge clk);
    wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
    ackCount = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (wbAck) ackCount++;
      @(negedge clk);
    end
    cpuReq = 1'b0;
    checkOutput("abort_no_ack", ackCount, 0);
    applyStimulus(1'b0, BASE + 32'd48, 32'h0, 4'hF, rd, lat);
    checkOutput("abort_no_write", rd, 32'h0C0C_0C0C);

    // Run / stop lamp.
    applyStimulus(1'b1, CTRL_A, 32'h1, 4'hF, rd, lat);
    checkOutput("run_crstn", cpuRstN, 1);
    checkOutput("run_run", cpuRun, 1);
    checkOutput("run_irq_idle", irq, 0);
    @(negedge clk);
    stopLamp = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("stop_run", cpuRun, 0);
    checkOutput("stop_irq", irq, 1);
    applyStimulus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat);
    checkOutput("stop_stat", rd, 32'h3);
    applyStimulus(1'b0, CTRL_A, 32'h0, 4'hF, rd, lat);
    checkOutput("stop_ctrl", rd, 32'h0);
    stopLamp = 1'b0;
    applyStimulus(1'b1, STAT_A, 32'h2, 4'hF, rd, lat);
    checkOutput("clr_irq", irq, 0);
    applyStimulus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat);
    checkOutput("clr_stat", rd, 32'h0);
    // A lamp edge while not running must not latch STOPPED.
    @(negedge clk);
    stopLamp = 1'b1;
    applyStimulus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat);
    checkOutput("idle_lamp_stat", rd, 32'h1);
    checkOutput("idle_lamp_irq", irq, 0);
    stopLamp = 1'b0;

    // Parity injection and check.
    applyStimulus(1'b1, CTRL_A, 32'h4, 4'hF, rd, lat);
    applyStimulus(1'b1, BASE + 32'd36, 32'h1111_1111, 4'hF, rd, lat);
    cpuAccess(1'b0, 5'd9, '0, gnt);
    checkOutput("par_cpu_data", cpuDataO, 32'h1111_1111);
    checkOutput("par_irq", irq, 32'(PAR_ON));
    applyStimulus(1'b0, STAT_A, 32'h0, 4'hF, rd, lat);
    checkOutput("par_stat", rd, PAR_ON ? 32'h4 : 32'h0);
    applyStimulus(1'b0, CTRL_A, 32'h0, 4'hF, rd, lat);
    checkOutput("par_inj_clr", rd, 32'h0);
    applyStimulus(1'b1, STAT_A, 32'h4, 4'hF, rd, lat);
    checkOutput("par_clr_irq", irq, 0);
    applyStimulus(1'b1, BASE + 32'd36, 32'h2222_2222, 4'hF, rd, lat);
    cpuAccess(1'b0, 5'd9, '0, gnt);
    checkOutput("par_clean_data", cpuDataO, 32'h2222_2222);
    checkOutput("par_clean_irq", irq, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
